// File: rtl/mul_share_if.sv
// Handshake bundle between two operand requesters, the shared multiplier
// and the single result consumer.
interface mul_share_if;
    logic        req0_valid;
    logic [23:0] req0_a;
    logic [25:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [23:0] req1_a;
    logic [25:0] req1_b;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_id;
    logic [49:0] rsp_z;
    logic        rsp_ready;
    logic        busy;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, busy
    );
endinterface

// File: rtl/mul_share_arb.sv
// Two-requester round-robin front end sharing one 26x24 Wallace multiplier.
// Optional per-requester accept counters: define MUL_SHARE_CNT_EN.

module mul_share_wallace (
    input  logic [23:0] a,
    input  logic [25:0] b,
    output logic [49:0] z
);
    // Rows are reduced three-into-two with carry-save adders until two remain.
    always_comb begin
        logic [49:0] w [24];
        logic [49:0] s;
        logic [49:0] c;
        int          n;
        int          m;
        s = '0;
        c = '0;
        m = 0;
        for (int i = 0; i < 24; i++) begin
            w[i] = ({24'b0, b} << i) & {50{a[i]}};
        end
        n = 24;
        for (int lvl = 0; lvl < 8; lvl++) begin
            if (n > 2) begin
                m = 0;
                for (int g = 0; g < 8; g++) begin
                    if (3 * g + 2 < n) begin
                        s = w[3*g] ^ w[3*g+1] ^ w[3*g+2];
                        c = ((w[3*g] & w[3*g+1]) | (w[3*g] & w[3*g+2]) |
                             (w[3*g+1] & w[3*g+2])) << 1;
                        w[m]   = s;
                        w[m+1] = c;
                        m      = m + 2;
                    end
                end
                for (int r = 0; r < 24; r++) begin
                    if (r >= 3 * (n / 3) && r < n) begin
                        w[m] = w[r];
                        m    = m + 1;
                    end
                end
                n = m;
            end
        end
        z = w[0] + w[1];
    end
endmodule

module mul_share_arb (
    input  logic        clk,
    input  logic        clrn,
`ifdef MUL_SHARE_CNT_EN
    output logic [15:0] cnt0,
    output logic [15:0] cnt1,
`endif
    mul_share_if.slave  bus
);
    logic        vld_p1;
    logic [23:0] a_p1;
    logic [25:0] b_p1;
    logic        id_p1;
    logic [49:0] prod_p1;
    logic        last_id;
    logic        gnt;
    logic        acc;
    logic        s1_load;
    logic        s2_load;

    mul_share_wallace u_wallace (
        .a (a_p1),
        .b (b_p1),
        .z (prod_p1)
    );

    // With both requesting, the one not served last wins; otherwise whoever asks.
    assign gnt     = (bus.req0_valid & bus.req1_valid) ? ~last_id : bus.req1_valid;
    assign s2_load = vld_p1 & (~bus.rsp_valid | bus.rsp_ready);
    assign s1_load = ~vld_p1 | s2_load;
    assign acc     = s1_load & (gnt ? bus.req1_valid : bus.req0_valid);

    assign bus.req0_ready = s1_load & ~gnt;
    assign bus.req1_ready = s1_load & gnt;
    assign bus.busy       = vld_p1 | bus.rsp_valid;

    // Stage 1: granted operands
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            vld_p1  <= 1'b0;
            a_p1    <= '0;
            b_p1    <= '0;
            id_p1   <= 1'b0;
            last_id <= 1'b1;
        end else if (s1_load) begin
            vld_p1 <= acc;
            if (acc) begin
                a_p1    <= gnt ? bus.req1_a : bus.req0_a;
                b_p1    <= gnt ? bus.req1_b : bus.req0_b;
                id_p1   <= gnt;
                last_id <= gnt;
            end
        end
    end

    // Stage 2: product on the response channel
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_z     <= '0;
        end else if (s2_load) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= id_p1;
            bus.rsp_z     <= prod_p1;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end

`ifdef MUL_SHARE_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (acc) begin
            if (gnt) cnt1 <= sat_inc(cnt1);
            else     cnt0 <= sat_inc(cnt0);
        end
    end
`endif
endmodule

// File: tb/tb_mul_share_arb.sv
// Randomized and directed bench for mul_share_arb against a behavioural
// two-slot pipeline model plus an in-order result scoreboard.
module tb_mul_share_arb;
    logic clk;
    logic clrn;
    int   checks   = 0;
    int   failures = 0;

    mul_share_if ifc ();

`ifdef MUL_SHARE_CNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    mul_share_arb dut (.clk(clk), .clrn(clrn), .cnt0(cnt0), .cnt1(cnt1), .bus(ifc));
`else
    mul_share_arb dut (.clk(clk), .clrn(clrn), .bus(ifc));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          id;
        logic [49:0] z;
    } ent_t;

    ent_t        sb [$];
    bit          m_s1_v, m_s2_v, m_last, m_s1_id, m_s2_id;
    logic [49:0] m_s1_z, m_s2_z;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_s1_v = 0; m_s2_v = 0; m_last = 1; m_s1_id = 0; m_s2_id = 0;
        m_s1_z = '0; m_s2_z = '0;
        sb.delete();
    endtask

    task automatic drive_idle();
        ifc.req0_valid = 0; ifc.req0_a = '0; ifc.req0_b = '0;
        ifc.req1_valid = 0; ifc.req1_a = '0; ifc.req1_b = '0;
        ifc.rsp_ready  = 0;
    endtask

    task automatic cycle(input bit v0, input logic [23:0] a0, input logic [25:0] b0,
                         input bit v1, input logic [23:0] a1, input logic [25:0] b1,
                         input bit rr, output int gnt_o, output bit rv_o,
                         output logic [49:0] rz_o, output bit rid_o);
        bit   adv, can_acc, g, acc;
        ent_t e;
        @(negedge clk);
        ifc.req0_valid = v0; ifc.req0_a = a0; ifc.req0_b = b0;
        ifc.req1_valid = v1; ifc.req1_a = a1; ifc.req1_b = b1;
        ifc.rsp_ready  = rr;
        #1;
        adv     = m_s1_v && (!m_s2_v || rr);
        can_acc = !m_s1_v || adv;
        g       = (v0 && v1) ? !m_last : v1;
        acc     = can_acc && (g ? v1 : v0);
        chk("req0_ready", 64'(ifc.req0_ready), 64'(can_acc && !g));
        chk("req1_ready", 64'(ifc.req1_ready), 64'(can_acc && g));
        chk("rsp_valid", 64'(ifc.rsp_valid), 64'(m_s2_v));
        chk("busy", 64'(ifc.busy), 64'(m_s1_v || m_s2_v));
        if (m_s2_v) begin
            chk("rsp_id", 64'(ifc.rsp_id), 64'(m_s2_id));
            chk("rsp_z", 64'(ifc.rsp_z), 64'(m_s2_z));
        end
        if (ifc.rsp_valid && rr) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_underflow actual=result required=none");
            end else begin
                e = sb.pop_front();
                chk("sb_id", 64'(ifc.rsp_id), 64'(e.id));
                chk("sb_z", 64'(ifc.rsp_z), 64'(e.z));
            end
        end
        gnt_o = acc ? int'(g) : -1;
        rv_o  = ifc.rsp_valid;
        rz_o  = ifc.rsp_z;
        rid_o = ifc.rsp_id;
        if (adv) begin
            m_s2_v = 1; m_s2_id = m_s1_id; m_s2_z = m_s1_z;
        end else if (rr) begin
            m_s2_v = 0;
        end
        if (can_acc) begin
            m_s1_v = acc;
            if (acc) begin
                m_s1_id = g;
                m_s1_z  = g ? {26'b0, a1} * {24'b0, b1} : {26'b0, a0} * {24'b0, b0};
                m_last  = g;
                e.id = g; e.z = m_s1_z;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle_cycle(input bit rr, output int g, output bit rv,
                              output logic [49:0] rz, output bit rid);
        cycle(0, '0, '0, 0, '0, '0, rr, g, rv, rz, rid);
    endtask

    initial begin
        int          g, n_acc;
        bit          rv, rid;
        logic [49:0] rz;
        logic [23:0] ra0, ra1;
        logic [25:0] rb0, rb1;

        clrn = 0;
        drive_idle();
        m_reset();
        #3;
        chk("rst_rsp_valid", 64'(ifc.rsp_valid), 64'(0));
        chk("rst_busy", 64'(ifc.busy), 64'(0));
        chk("rst_rsp_z", 64'(ifc.rsp_z), 64'(0));
        chk("rst_req0_ready", 64'(ifc.req0_ready), 64'(1));
        chk("rst_req1_ready", 64'(ifc.req1_ready), 64'(0));
        @(negedge clk);
        clrn = 1;

        // Round robin after reset: grants and response ids alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            cycle(1, 24'(i + 1), 26'd2, 1, 24'(i + 9), 26'd3, 1, g, rv, rz, rid);
            chk("rr_grant", 64'(g), 64'(i % 2));
            if (i >= 2) begin
                chk("rr_rsp_valid", 64'(rv), 64'(1));
                chk("rr_rsp_id", 64'(rid), 64'(i % 2));
            end
        end
        for (int i = 4; i < 6; i++) begin
            idle_cycle(1, g, rv, rz, rid);
            chk("rr_rsp_valid", 64'(rv), 64'(1));
            chk("rr_rsp_id", 64'(rid), 64'(i % 2));
        end
        idle_cycle(1, g, rv, rz, rid);

        // 3 * 5 with one cycle of latency
        cycle(1, 24'd3, 26'd5, 0, '0, '0, 1, g, rv, rz, rid);
        chk("lat_grant", 64'(g), 64'(0));
        @(posedge clk); #1;
        chk("lat_k_rsp_valid", 64'(ifc.rsp_valid), 64'(0));
        idle_cycle(1, g, rv, rz, rid);
        @(posedge clk); #1;
        chk("lat_k1_rsp_valid", 64'(ifc.rsp_valid), 64'(1));
        chk("lat_rsp_z", 64'(ifc.rsp_z), 64'(15));
        chk("lat_rsp_id", 64'(ifc.rsp_id), 64'(0));
        idle_cycle(1, g, rv, rz, rid);

        // Largest operands from requester 1
        cycle(0, '0, '0, 1, 24'hFFFFFF, 26'h3FFFFFF, 1, g, rv, rz, rid);
        idle_cycle(1, g, rv, rz, rid);
        @(posedge clk); #1;
        chk("max_rsp_z", 64'(ifc.rsp_z), 64'(50'h3FFFFFB000001));
        chk("max_rsp_id", 64'(ifc.rsp_id), 64'(1));
        idle_cycle(1, g, rv, rz, rid);
        idle_cycle(1, g, rv, rz, rid);

        // Backpressure: only two accepted, output held, then ordered drain
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 24'(100 + i), 26'd7, 0, '0, '0, 0, g, rv, rz, rid);
            if (g >= 0) n_acc++;
            if (i >= 2) begin
                chk("bp_rsp_valid", 64'(rv), 64'(1));
                chk("bp_rsp_z_stable", 64'(rz), 64'(700));
            end
        end
        chk("bp_accepts", 64'(n_acc), 64'(2));
        idle_cycle(1, g, rv, rz, rid);
        chk("drain0_z", 64'(rz), 64'(700));
        idle_cycle(1, g, rv, rz, rid);
        chk("drain1_z", 64'(rz), 64'(707));
        chk("drain1_valid", 64'(rv), 64'(1));
        idle_cycle(1, g, rv, rz, rid);
        chk("drain_empty", 64'(rv), 64'(0));

        // Asynchronous reset with both stages full
        cycle(1, 24'd5, 26'd6, 0, '0, '0, 0, g, rv, rz, rid);
        cycle(0, '0, '0, 1, 24'd7, 26'd8, 0, g, rv, rz, rid);
        @(posedge clk); #1;
        chk("pre_rst_busy", 64'(ifc.busy), 64'(1));
        chk("pre_rst_rsp_valid", 64'(ifc.rsp_valid), 64'(1));
        clrn = 0;
        drive_idle();
        #1;
        chk("arst_rsp_valid", 64'(ifc.rsp_valid), 64'(0));
        chk("arst_busy", 64'(ifc.busy), 64'(0));
        chk("arst_rsp_z", 64'(ifc.rsp_z), 64'(0));
        m_reset();
        @(negedge clk);
        clrn = 1;
        for (int i = 0; i < 3; i++) begin
            idle_cycle(1, g, rv, rz, rid);
            chk("no_stale", 64'(rv), 64'(0));
        end
        cycle(1, 24'd2, 26'd2, 1, 24'd3, 26'd3, 1, g, rv, rz, rid);
        chk("post_rst_grant", 64'(g), 64'(0));
        idle_cycle(1, g, rv, rz, rid);
        idle_cycle(1, g, rv, rz, rid);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ra0 = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
            rb0 = ($urandom_range(0, 7) == 0) ? 26'h3FFFFFF : 26'($urandom);
            ra1 = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
            rb1 = ($urandom_range(0, 7) == 0) ? 26'h3FFFFFF : 26'($urandom);
            cycle($urandom_range(0, 3) != 0, ra0, rb0, $urandom_range(0, 3) != 0, ra1, rb1,
                  $urandom_range(0, 3) != 0, g, rv, rz, rid);
        end
        for (int i = 0; i < 3; i++) idle_cycle(1, g, rv, rz, rid);
        chk("sb_empty", 64'(sb.size()), 64'(0));

`ifdef MUL_SHARE_CNT_EN
        @(negedge clk);
        clrn = 0;
        drive_idle();
        m_reset();
        #1;
        chk("cnt0_rst", 64'(cnt0), 64'(0));
        @(negedge clk);
        clrn = 1;
        for (int i = 0; i < 70000; i++) begin
            cycle(1, 24'($urandom), 26'($urandom), 0, '0, '0, 1, g, rv, rz, rid);
        end
        @(posedge clk); #1;
        chk("cnt0_sat", 64'(cnt0), 64'(16'hFFFF));
        chk("cnt1_zero", 64'(cnt1), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_share_arb.md
MUL_SHARE_ARB -- requirements
Module: mul_share_arb

Interface
REQ-001 Parameters: none; operand and product widths are fixed at 24 x 26 -> 50 bits.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 clrn  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 presents an operation.
REQ-005 req0_a  input  24  requester 0 operand a (unsigned).
REQ-006 req0_b  input  26  requester 0 operand b (unsigned).
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle when req0_valid is also high.
REQ-008 req1_valid, req1_a[23:0], req1_b[25:0], req1_ready: same directions and meaning for requester 1.
REQ-009 rsp_valid  output  1  result present on the shared response channel.
REQ-010 rsp_id  output  1  requester that owns the result.
REQ-011 rsp_z  output  50  unsigned product a*b.
REQ-012 rsp_ready  input  1  consumer accepts the result this cycle.
REQ-013 busy  output  1  high when either pipeline stage holds a valid entry.

Function
REQ-014 The block SHALL instantiate exactly one 26x24 Wallace product unit and share it between the two requesters.
REQ-015 Pipeline: stage S1 registers the granted a, b and id; the product of S1 operands is captured into S2 (rsp_z, rsp_id, rsp_valid).
REQ-016 Latency: an operation handshaken at edge k SHALL appear on rsp_valid/rsp_z after edge k+1 if S2 is free.
REQ-017 Advance rules: s2_load = s1_valid & (~rsp_valid | rsp_ready); s1_load = ~s1_valid | s2_load.
REQ-018 reqN_ready SHALL be high only when s1_load is high and requester N holds the grant; the non-granted ready SHALL be low.
REQ-019 Arbitration: when one requester is valid it SHALL be granted; when both are valid, the requester not served last SHALL be granted (round robin).
REQ-020 The last-served pointer SHALL update only on an accepted handshake (valid & ready).
REQ-021 Backpressure: with rsp_valid high and rsp_ready low, S2 SHALL hold; S1 SHALL hold if full; both readys SHALL be low once S1 is full.
REQ-022 Full throughput: with rsp_ready held high, one operation SHALL be accepted per cycle.
REQ-023 Simultaneous rsp handshake and S2 load in the same cycle SHALL replace S2 with the new result without a bubble.
REQ-024 rsp_z SHALL equal the exact 50-bit unsigned product; no truncation or rounding.
REQ-025 S2 contents SHALL stay stable while rsp_valid is high and rsp_ready is low.
REQ-026 busy = s1_valid | rsp_valid.

Reset
REQ-027 On clrn low, s1_valid, rsp_valid, rsp_id, rsp_z and the S1 registers SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-028 Reset SHALL set the last-served pointer to 1, so requester 0 wins the first contention.
REQ-029 Operations in flight at reset SHALL be discarded; no result SHALL emerge after clrn returns high.

Configuration
REQ-030 Macro MUL_SHARE_CNT_EN defined: outputs cnt0[15:0] and cnt1[15:0] SHALL count accepted handshakes per requester, reset to 0, and saturate at 16'hFFFF.
REQ-031 Macro MUL_SHARE_CNT_EN undefined: the cnt0/cnt1 ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 req0 a=3, b=5, rsp_ready=1 -> rsp_valid high after edge k+1, rsp_z=15, rsp_id=0.
REQ-033 req1 a=24'hFFFFFF, b=26'h3FFFFFF -> rsp_z=50'h3FFFFFB000001, rsp_id=1.
REQ-034 Both valid for 4 cycles after reset, rsp_ready=1 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1 on consecutive cycles.
REQ-035 rsp_ready=0 for 5 cycles with continuous requests -> exactly 2 accepted, rsp_z stable; rsp_ready=1 -> both drain in order with no loss or duplication.
REQ-036 clrn pulsed low with S1 and S2 full -> rsp_valid=0 and busy=0 immediately; no stale result afterward; next contention granted to req0.
REQ-037 With MUL_SHARE_CNT_EN, 70000 req0 accepts -> cnt0=16'hFFFF and cnt1=0.
